// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, default latencies and the pipeline NOP word.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HOLD   = 2'd3
    } hazard_state_t;

    localparam int DEF_MUL_LAT      = 4;
    localparam int DEF_DIV_LAT      = 32;
    localparam int DEF_DRAIN_CYCLES = 4;

    // Bubble word that RegPipeline users load on a clear.
    localparam logic [31:0] NOP_INSTR = 32'd0;

endpackage

// File: rtl/hazard_down_counter.sv
// Loadable down-counter shared by the mult/div stall and the drain sequence.
// Latency: value updates one clock after load/dec; zero is combinational from value.
// Backpressure: none; dec is ignored while the count is already zero.
module hazard_down_counter #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(negedge clock) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use, taken-branch, mult/div stalls and loader drain/hold.
// Latency: branch and load-use controls are same-cycle combinational; FSM state moves on negedge.
// Backpressure: stalls PC and IF/ID while busy; loader waits for hold_ack before writing memory.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT      = DEF_MUL_LAT,
    parameter int DIV_LAT      = DEF_DIV_LAT,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_muldiv_start,
    input  logic       id_muldiv_is_div,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    input  logic       hold_req,
    output logic       hold_ack,
    output logic       pc_parada,
    output logic       if_id_parada,
    output logic       if_id_limpar,
    output logic       id_ex_limpar,
    output logic       muldiv_busy
);

    localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    hazard_state_t state, state_nxt;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_value;
    logic          cnt_dec;
    logic [CW-1:0] cnt_value;
    logic          cnt_zero;
    logic          load_use;

    hazard_down_counter #(.W(CW)) u_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    // $zero is hardwired, so a load targeting it never forwards a real value.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(negedge clock) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;
        hold_ack       = 1'b0;
        pc_parada      = 1'b0;
        if_id_parada   = 1'b0;
        if_id_limpar   = 1'b0;
        id_ex_limpar   = 1'b0;
        muldiv_busy    = 1'b0;

        case (state)
            ST_RUN: begin
                // A taken branch makes the ID instruction wrong-path, so nothing it asks for counts.
                if (ex_branch_taken) begin
                    if_id_limpar = 1'b1;
                    id_ex_limpar = 1'b1;
                end else if (load_use) begin
                    pc_parada    = 1'b1;
                    if_id_parada = 1'b1;
                    id_ex_limpar = 1'b1;
                end else if (id_muldiv_start) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = id_muldiv_is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
                    state_nxt      = ST_MULDIV;
                end else if (hold_req) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = CW'(DRAIN_CYCLES - 1);
                    state_nxt      = ST_DRAIN;
                end
            end
            ST_MULDIV: begin
                pc_parada    = 1'b1;
                if_id_parada = 1'b1;
                id_ex_limpar = 1'b1;
                muldiv_busy  = 1'b1;
                if (cnt_zero) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_parada    = 1'b1;
                if_id_limpar = 1'b1;
                if (cnt_zero) begin
                    state_nxt = ST_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                pc_parada    = 1'b1;
                if_id_limpar = 1'b1;
                hold_ack     = 1'b1;
                if (!hold_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        if (!reset_n) begin
            cnt_load     = 1'b0;
            cnt_dec      = 1'b0;
            hold_ack     = 1'b0;
            pc_parada    = 1'b0;
            if_id_parada = 1'b0;
            if_id_limpar = 1'b0;
            id_ex_limpar = 1'b0;
            muldiv_busy  = 1'b0;
        end
    end

endmodule
